// File: rtl/rtc_time_counter.sv
// Time-of-day counter: divides clk into a one-second advance and keeps a 24-hour hh:mm:ss count.
// Also accepts a validated time-load strobe with ack/err pulses.
module rtc_time_counter #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       time_set,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  output logic [4:0] hour_rtc,
  output logic [5:0] min_rtc,
  output logic [5:0] sec_rtc,
  output logic       sec_tick,
  output logic       set_ack,
  output logic       set_err
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } hms_t;

  function automatic logic load_valid(input logic [4:0] h, input logic [5:0] m,
                                      input logic [5:0] s);
    return (h <= 5'd23) && (m <= 6'd59) && (s <= 6'd59);
  endfunction

  // Cascaded seconds -> minutes -> hours increment with 23:59:59 wrapping to midnight.
  function automatic hms_t hms_incr(input hms_t t);
    hms_t n;
    n = t;
    if (t.sec != 6'd59) begin
      n.sec = t.sec + 6'd1;
    end else begin
      n.sec = '0;
      if (t.min != 6'd59) begin
        n.min = t.min + 6'd1;
      end else begin
        n.min  = '0;
        n.hour = (t.hour == 5'd23) ? 5'd0 : t.hour + 5'd1;
      end
    end
    return n;
  endfunction

  logic [PW-1:0] presc;
  logic          load_ok;
  logic          advance;
  hms_t          cur_time;
  hms_t          next_time;

  assign load_ok   = time_set && load_valid(set_hour, set_min, set_sec);
  assign advance   = run && (presc == PRESC_LAST);
  assign cur_time  = {hour_rtc, min_rtc, sec_rtc};
  assign next_time = hms_incr(cur_time);

  // A valid load wins over a same-edge advance; a rejected load lets the advance through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc    <= '0;
      hour_rtc <= '0;
      min_rtc  <= '0;
      sec_rtc  <= '0;
      sec_tick <= 1'b0;
      set_ack  <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      set_ack  <= 1'b0;
      set_err  <= time_set && !load_ok;
      if (load_ok) begin
        presc    <= '0;
        hour_rtc <= set_hour;
        min_rtc  <= set_min;
        sec_rtc  <= set_sec;
        set_ack  <= 1'b1;
      end else if (advance) begin
        presc    <= '0;
        hour_rtc <= next_time.hour;
        min_rtc  <= next_time.min;
        sec_rtc  <= next_time.sec;
        sec_tick <= 1'b1;
      end else if (run) begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule
